// File: rtl/time_display_scan.sv
// Scans a packed HH:MM:SS time bus onto a six-digit multiplexed common-anode 7-segment display.
// Optional ALARM_BLINK_EN: blanks the display on alternate BLINK_DIV periods while the alarm is high.
module time_display_scan #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter int unsigned BLINK_DIV      = 25000000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] timeBus,
  input  logic        neg_alarm_s,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [5:0]  an,
  output logic        alarm_led
);

  localparam int unsigned PW      = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0]  DASH    = 4'hF;
  localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic        DP_OFF  = SEG_ACTIVE_LOW ? 1'b1 : 1'b0;
  localparam logic [5:0]  AN_OFF  = AN_ACTIVE_LOW ? 6'h3F : 6'h00;

  logic [PW-1:0] presc_q, presc_d;
  logic [2:0]    idx_q, idx_d;
  logic [4:0]    hrs_q, hrs_d;
  logic [5:0]    min_q, min_d, sec_q, sec_d;
  logic          loaded_q, alarm_q;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic [5:0]    an_q, an_d;
  logic          tc, load, blank, dp_lit;
  logic          hrs_bad, min_bad, sec_bad;
  logic [3:0]    digit;
  logic [6:0]    pat;

`ifdef ALARM_BLINK_EN
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  logic [BW-1:0] blink_q, blink_d;
  logic          phase_q, phase_d;

  // Blink timebase only runs while the registered alarm is up; otherwise parked at phase 0.
  always_comb begin
    blink_d = '0;
    phase_d = 1'b0;
    if (alarm_q) begin
      if (blink_q == BW'(BLINK_DIV - 1)) begin
        blink_d = '0;
        phase_d = ~phase_q;
      end else begin
        blink_d = blink_q + 1'b1;
        phase_d = phase_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      blink_q <= '0;
      phase_q <= 1'b0;
    end else begin
      blink_q <= blink_d;
      phase_q <= phase_d;
    end
  end

  assign blank = alarm_q & phase_q;
`else
  assign blank = 1'b0;
`endif

  // Scan timebase, digit index and frame snapshot (reloaded only at end of frame).
  always_comb begin
    tc      = (presc_q == PW'(SCAN_DIV - 1));
    presc_d = tc ? '0 : presc_q + 1'b1;
    idx_d   = idx_q;
    if (tc) idx_d = (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
    load  = !loaded_q || (tc && (idx_q == 3'd5));
    hrs_d = load ? timeBus[20:16] : hrs_q;
    min_d = load ? timeBus[13:8]  : min_q;
    sec_d = load ? timeBus[5:0]   : sec_q;
  end

  // Digit select, BCD split and segment encode for the current index.
  always_comb begin
    hrs_bad = (hrs_q > 5'd23);
    min_bad = (min_q > 6'd59);
    sec_bad = (sec_q > 6'd59);
    case (idx_q)
      3'd0:    digit = sec_bad ? DASH : 4'(sec_q % 6'd10);
      3'd1:    digit = sec_bad ? DASH : 4'(sec_q / 6'd10);
      3'd2:    digit = min_bad ? DASH : 4'(min_q % 6'd10);
      3'd3:    digit = min_bad ? DASH : 4'(min_q / 6'd10);
      3'd4:    digit = hrs_bad ? DASH : 4'(hrs_q % 5'd10);
      3'd5:    digit = hrs_bad ? DASH : 4'(hrs_q / 5'd10);
      default: digit = DASH;
    endcase
    case (digit)
      4'd0:    pat = 7'b0111111;
      4'd1:    pat = 7'b0000110;
      4'd2:    pat = 7'b1011011;
      4'd3:    pat = 7'b1001111;
      4'd4:    pat = 7'b1100110;
      4'd5:    pat = 7'b1101101;
      4'd6:    pat = 7'b1111101;
      4'd7:    pat = 7'b0000111;
      4'd8:    pat = 7'b1111111;
      4'd9:    pat = 7'b1101111;
      default: pat = 7'b1000000;
    endcase
    dp_lit = (idx_q == 3'd2) || (idx_q == 3'd4);
    seg_d  = SEG_OFF;
    dp_d   = DP_OFF;
    an_d   = AN_OFF;
    // Nothing is lit until the first snapshot has been taken.
    if (loaded_q && !blank) begin
      seg_d = SEG_ACTIVE_LOW ? ~pat : pat;
      dp_d  = SEG_ACTIVE_LOW ? ~dp_lit : dp_lit;
      an_d  = AN_ACTIVE_LOW ? ~(6'd1 << idx_q) : (6'd1 << idx_q);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_q  <= '0;
      idx_q    <= 3'd0;
      hrs_q    <= 5'd0;
      min_q    <= 6'd0;
      sec_q    <= 6'd0;
      loaded_q <= 1'b0;
      alarm_q  <= 1'b0;
      seg_q    <= SEG_OFF;
      dp_q     <= DP_OFF;
      an_q     <= AN_OFF;
    end else begin
      presc_q  <= presc_d;
      idx_q    <= idx_d;
      hrs_q    <= hrs_d;
      min_q    <= min_d;
      sec_q    <= sec_d;
      loaded_q <= 1'b1;
      alarm_q  <= neg_alarm_s;
      seg_q    <= seg_d;
      dp_q     <= dp_d;
      an_q     <= an_d;
    end
  end

  assign seg       = seg_q;
  assign dp        = dp_q;
  assign an        = an_q;
  assign alarm_led = alarm_q;

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan: expected digit presentations are queued by the
// stimulus and popped by a monitor each time a new digit is enabled.
module tb_time_display_scan;

  localparam int unsigned SCAN_DIV  = 4;
  localparam int unsigned BLINK_DIV = 8;
  localparam int          DASH      = 10;

  logic        clk, rst, neg_alarm_s;
  logic [23:0] timeBus;
  logic [6:0]  seg;
  logic        dp;
  logic [5:0]  an;
  logic        alarm_led;

  int          checks   = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  logic [5:0]  prev_an  = 6'h3F;

  time_display_scan #(
    .SCAN_DIV      (SCAN_DIV),
    .BLINK_DIV     (BLINK_DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .timeBus    (timeBus),
    .neg_alarm_s(neg_alarm_s),
    .seg        (seg),
    .dp         (dp),
    .an         (an),
    .alarm_led  (alarm_led)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [23:0] tb_time(input int h, input int m, input int s, input bit fill);
    return {{3{fill}}, 5'(h), {2{fill}}, 6'(m), {2{fill}}, 6'(s)};
  endfunction

  // Active-high {g,f,e,d,c,b,a}; DASH maps to g only.
  function automatic logic [6:0] seg_pat(input int d);
    case (d)
      0: return 7'b0111111;
      1: return 7'b0000110;
      2: return 7'b1011011;
      3: return 7'b1001111;
      4: return 7'b1100110;
      5: return 7'b1101101;
      6: return 7'b1111101;
      7: return 7'b0000111;
      8: return 7'b1111111;
      9: return 7'b1101111;
      default: return 7'b1000000;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the first n digits (index order: sec ones .. hours tens) of one frame.
  task automatic push_frame(input int n, input int d0, input int d1, input int d2,
                            input int d3, input int d4, input int d5);
    int d[6];
    logic [5:0] a;
    logic [6:0] s;
    logic p;
    d = '{d0, d1, d2, d3, d4, d5};
    for (int i = 0; i < n; i++) begin
      a = ~(6'd1 << i);
      s = ~seg_pat(d[i]);
      p = !((i == 2) || (i == 4));
      exp_q.push_back({a, s, p});
    end
  endtask

  task automatic drain(input string name, input int budget);
    for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk);
    check(name, 32'(exp_q.size()), 32'd0);
  endtask

  task automatic do_reset(input logic [23:0] tb);
    @(negedge clk);
    #2 rst = 1'b0;
    timeBus = tb;
    repeat (2) @(negedge clk);
  endtask

  task automatic release_rst;
    @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: a change to a new enabled digit is one presentation.
  always @(negedge clk) begin
    logic [13:0] e;
    if (!rst) begin
      prev_an = 6'h3F;
    end else begin
      if (an != prev_an && an != 6'h3F && exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("digit", 32'({an, seg, dp}), 32'(e));
      end
      prev_an = an;
    end
  end

  initial begin
    int blanks, run, max_run, lit_ok;
    rst         = 1'b1;
    neg_alarm_s = 1'b0;
    timeBus     = tb_time(12, 34, 56, 1'b0);
    #3 rst = 1'b0;
    #1;
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_alarm_led", 32'(alarm_led), 32'h0);

    // Held 12:34:56, then changed mid-frame; frame must not tear.
    repeat (2) @(negedge clk);
    push_frame(6, 6, 5, 4, 3, 2, 1);
    push_frame(6, 5, 5, 3, 4, 1, 2);
    release_rst();
    repeat (10) @(negedge clk);
    timeBus = tb_time(21, 43, 55, 1'b0);
    drain("drain_tear", 200);

    // 23:59:59 boundary, then out-of-range fields; fill bits set to 1.
    do_reset(tb_time(23, 59, 59, 1'b1));
    push_frame(6, 9, 5, 9, 5, 3, 2);
    push_frame(6, 9, 0, DASH, DASH, DASH, DASH);
    release_rst();
    repeat (10) @(negedge clk);
    timeBus = tb_time(25, 60, 9, 1'b1);
    drain("drain_range", 200);

    // Reset while digit 3 is lit, then restart on 00:00:00.
    do_reset(tb_time(23, 59, 59, 1'b0));
    push_frame(4, 9, 5, 9, 5, 3, 2);
    release_rst();
    repeat (14) @(negedge clk);
    check("mid_pending", 32'(exp_q.size()), 32'd0);
    check("mid_an_before", 32'(an), 32'h37);
    #2 rst = 1'b0;
    #1;
    check("mid_rst_seg", 32'(seg), 32'h7F);
    check("mid_rst_an", 32'(an), 32'h3F);
    check("mid_rst_dp", 32'(dp), 32'h1);
    timeBus = tb_time(0, 0, 0, 1'b1);
    push_frame(6, 0, 0, 0, 0, 0, 0);
    push_frame(6, 0, 0, 0, 0, 0, 0);
    release_rst();
    drain("drain_restart", 200);

    // Alarm: registered LED and optional blanking.
    do_reset(tb_time(0, 0, 0, 1'b0));
    release_rst();
    repeat (30) @(negedge clk);
    neg_alarm_s = 1'b1;
    #1 check("alarm_led_pre", 32'(alarm_led), 32'h0);
    @(negedge clk);
    check("alarm_led_rise", 32'(alarm_led), 32'h1);
    repeat (4) @(negedge clk);
    blanks = 0; run = 0; max_run = 0; lit_ok = 0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (an == 6'h3F && seg == 7'h7F && dp == 1'b1) begin
        blanks++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
        if ($countones(~an) == 1) lit_ok++;
      end
    end
`ifdef ALARM_BLINK_EN
    check("blink_blanks", 32'(blanks), 32'd32);
    check("blink_run", 32'(max_run), 32'd8);
`else
    check("blink_blanks", 32'(blanks), 32'd0);
    check("blink_run", 32'(max_run), 32'd0);
`endif
    check("blink_lit", 32'(lit_ok), 32'(64 - blanks));
    neg_alarm_s = 1'b0;
    @(negedge clk);
    check("alarm_led_fall", 32'(alarm_led), 32'h0);
    repeat (3) @(negedge clk);
    blanks = 0;
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      if (an == 6'h3F) blanks++;
    end
    check("steady_blanks", 32'(blanks), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
